// File: rtl/itch_parse_arbiter.sv
// Priority arbiter over the speculative ITCH decoder bank feeding a result FIFO.
// Tracks conflict, invalid-packet and overflow events with saturating counters.
module itch_parse_arbiter #(
  parameter int NUM_DEC    = 4,
  parameter int PAYLOAD_W  = 192,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_DEC-1:0]             dec_valid,
  input  logic [NUM_DEC-1:0]             dec_invalid,
  input  logic [4*NUM_DEC-1:0]           dec_type,
  input  logic [PAYLOAD_W*NUM_DEC-1:0]   dec_payload,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [3:0]                     out_type,
  output logic [PAYLOAD_W-1:0]           out_payload,
  output logic                           out_conflict,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic                           conflict_pulse,
  output logic                           overflow_pulse,
  output logic [CNT_W-1:0]               conflict_cnt,
  output logic [CNT_W-1:0]               invalid_cnt,
  output logic [CNT_W-1:0]               drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic                 cand_valid;
  logic                 cand_conflict;
  logic [3:0]           cand_type;
  logic [PAYLOAD_W-1:0] cand_payload;

  logic [LW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level;
  logic          full, empty, push, pop, drop;

  logic                 conflict_pulse_q, conflict_pulse_d;
  logic                 overflow_pulse_q, overflow_pulse_d;
  logic [CNT_W-1:0]     conflict_cnt_q, conflict_cnt_d;
  logic [CNT_W-1:0]     invalid_cnt_q, invalid_cnt_d;
  logic [CNT_W-1:0]     drop_cnt_q, drop_cnt_d;

  logic [3:0]           mem_type_q    [FIFO_DEPTH];
  logic [PAYLOAD_W-1:0] mem_payload_q [FIFO_DEPTH];
  logic                 mem_conf_q    [FIFO_DEPTH];

  // Scan high to low so the lowest set index is the last (winning) write.
  always_comb begin
    cand_type    = '0;
    cand_payload = '0;
    for (int i = NUM_DEC - 1; i >= 0; i--) begin
      if (dec_valid[i]) begin
        cand_type    = dec_type[4*i +: 4];
        cand_payload = dec_payload[PAYLOAD_W*i +: PAYLOAD_W];
      end
    end
  end

  assign cand_valid    = |dec_valid;
  assign cand_conflict = (dec_valid & (dec_valid - 1'b1)) != '0;

  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = level == LW'(FIFO_DEPTH);
  assign empty = level == '0;
  assign pop   = !empty && out_ready;
  assign push  = cand_valid && (!full || pop);
  assign drop  = cand_valid && full && !pop;

  always_comb begin
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    conflict_pulse_d = cand_conflict;
    overflow_pulse_d = drop;
    conflict_cnt_d   = conflict_cnt_q;
    invalid_cnt_d    = invalid_cnt_q;
    drop_cnt_d       = drop_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (cand_conflict && conflict_cnt_q != '1)
      conflict_cnt_d = conflict_cnt_q + 1'b1;
    if (|dec_invalid && invalid_cnt_q != '1)
      invalid_cnt_d = invalid_cnt_q + 1'b1;
    if (drop && drop_cnt_q != '1)
      drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      conflict_pulse_q <= 1'b0;
      overflow_pulse_q <= 1'b0;
      conflict_cnt_q   <= '0;
      invalid_cnt_q    <= '0;
      drop_cnt_q       <= '0;
    end else begin
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      conflict_pulse_q <= conflict_pulse_d;
      overflow_pulse_q <= overflow_pulse_d;
      conflict_cnt_q   <= conflict_cnt_d;
      invalid_cnt_q    <= invalid_cnt_d;
      drop_cnt_q       <= drop_cnt_d;
    end
  end

  // Storage needs no reset: outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_type_q[wr_ptr_q[AW-1:0]]    <= cand_type;
      mem_payload_q[wr_ptr_q[AW-1:0]] <= cand_payload;
      mem_conf_q[wr_ptr_q[AW-1:0]]    <= cand_conflict;
    end
  end

  assign out_valid      = !empty;
  assign out_type       = empty ? '0 : mem_type_q[rd_ptr_q[AW-1:0]];
  assign out_payload    = empty ? '0 : mem_payload_q[rd_ptr_q[AW-1:0]];
  assign out_conflict   = empty ? 1'b0 : mem_conf_q[rd_ptr_q[AW-1:0]];
  assign fifo_level     = level;
  assign conflict_pulse = conflict_pulse_q;
  assign overflow_pulse = overflow_pulse_q;
  assign conflict_cnt   = conflict_cnt_q;
  assign invalid_cnt    = invalid_cnt_q;
  assign drop_cnt       = drop_cnt_q;

endmodule

// File: tb/tb_itch_parse_arbiter.sv
// Directed bench for itch_parse_arbiter with hand-computed expectations.
// Slice i of a drive(base) step carries type (base+i)[3:0], payload {24{base+i}}.
module tb_itch_parse_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   dec_valid;
  logic [3:0]   dec_invalid;
  logic [15:0]  dec_type;
  logic [767:0] dec_payload;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   out_type;
  logic [191:0] out_payload;
  logic         out_conflict;
  logic [2:0]   fifo_level;
  logic         conflict_pulse;
  logic         overflow_pulse;
  logic [15:0]  conflict_cnt;
  logic [15:0]  invalid_cnt;
  logic [15:0]  drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  itch_parse_arbiter dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_invalid(dec_invalid),
    .dec_type(dec_type), .dec_payload(dec_payload),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_type(out_type), .out_payload(out_payload),
    .out_conflict(out_conflict), .fifo_level(fifo_level),
    .conflict_pulse(conflict_pulse), .overflow_pulse(overflow_pulse),
    .conflict_cnt(conflict_cnt), .invalid_cnt(invalid_cnt),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [191:0] mk(input logic [7:0] t);
    return {24{t}};
  endfunction

  task automatic drive(input logic [3:0] v, input logic [3:0] inv,
                       input logic [7:0] b);
    logic [7:0] t;
    dec_valid   = v;
    dec_invalid = inv;
    for (int i = 0; i < 4; i++) begin
      t = b + 8'(i);
      dec_type[4*i +: 4]      = t[3:0];
      dec_payload[192*i +: 192] = mk(t);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [191:0] o,
                     input logic [191:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_valid"}, 192'(out_valid), 192'(0));
    chk({tag, "_level"}, 192'(fifo_level), 192'(0));
    chk({tag, "_type"}, 192'(out_type), 192'(0));
    chk({tag, "_payload"}, out_payload, 192'(0));
    chk({tag, "_conf"}, 192'(out_conflict), 192'(0));
    chk({tag, "_cpulse"}, 192'(conflict_pulse), 192'(0));
    chk({tag, "_opulse"}, 192'(overflow_pulse), 192'(0));
    chk({tag, "_ccnt"}, 192'(conflict_cnt), 192'(0));
    chk({tag, "_icnt"}, 192'(invalid_cnt), 192'(0));
    chk({tag, "_dcnt"}, 192'(drop_cnt), 192'(0));
  endtask

  initial begin
    logic [7:0] k;
    rst = 1'b1;
    out_ready = 1'b0;
    drive(4'b0000, 4'b0000, 8'h00);
    tick();
    tick();
    rst = 1'b0;
    chk_idle_zero("reset");

    // Single valid on decoder 2, type 4.
    out_ready = 1'b1;
    drive(4'b0100, 4'b0000, 8'h12);
    tick();
    chk("single_valid", 192'(out_valid), 192'(1));
    chk("single_type", 192'(out_type), 192'(4));
    chk("single_payload", out_payload, mk(8'h14));
    chk("single_conf", 192'(out_conflict), 192'(0));
    chk("single_level", 192'(fifo_level), 192'(1));
    chk("single_cpulse", 192'(conflict_pulse), 192'(0));
    drive(4'b0000, 4'b0000, 8'h00);
    tick();
    chk("single_popped", 192'(fifo_level), 192'(0));
    chk("single_empty", 192'(out_valid), 192'(0));

    // Two valids: decoder 1 wins, conflict flagged.
    drive(4'b1010, 4'b0000, 8'h20);
    tick();
    chk("conf_type", 192'(out_type), 192'(1));
    chk("conf_payload", out_payload, mk(8'h21));
    chk("conf_bit", 192'(out_conflict), 192'(1));
    chk("conf_pulse", 192'(conflict_pulse), 192'(1));
    chk("conf_cnt", 192'(conflict_cnt), 192'(1));
    drive(4'b0000, 4'b0000, 8'h00);
    tick();
    chk("conf_pulse_clr", 192'(conflict_pulse), 192'(0));
    chk("conf_level", 192'(fifo_level), 192'(0));

    // Fill with out_ready low; fifth result is dropped.
    out_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      drive(4'b0001, 4'b0000, 8'h30 + 8'(j));
      tick();
      if (j == 3) begin
        chk("fill_level4", 192'(fifo_level), 192'(4));
        chk("fill_noovf", 192'(overflow_pulse), 192'(0));
      end
    end
    chk("ovf_level", 192'(fifo_level), 192'(4));
    chk("ovf_pulse", 192'(overflow_pulse), 192'(1));
    chk("ovf_drop", 192'(drop_cnt), 192'(1));
    chk("ovf_head", 192'(out_type), 192'(0));
    chk("ovf_head_pl", out_payload, mk(8'h30));
    drive(4'b0000, 4'b0000, 8'h00);
    tick();
    chk("ovf_pulse_clr", 192'(overflow_pulse), 192'(0));
    chk("hold_head", out_payload, mk(8'h30));

    // Full with simultaneous pop and push: no drop.
    out_ready = 1'b1;
    drive(4'b0001, 4'b0000, 8'h35);
    tick();
    chk("fullpp_level", 192'(fifo_level), 192'(4));
    chk("fullpp_drop", 192'(drop_cnt), 192'(1));
    chk("fullpp_ovf", 192'(overflow_pulse), 192'(0));
    drive(4'b0000, 4'b0000, 8'h00);
    for (int j = 1; j <= 5; j++) begin
      if (j == 4) continue;
      k = 8'h30 + 8'(j);
      chk("drain_valid", 192'(out_valid), 192'(1));
      chk("drain_type", 192'(out_type), 192'(k[3:0]));
      chk("drain_payload", out_payload, mk(k));
      tick();
    end
    chk("drain_level", 192'(fifo_level), 192'(0));
    chk("drain_empty", 192'(out_valid), 192'(0));

    // Build level 3, then reset while a push is presented.
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      drive(4'b0011, 4'b0001, 8'h50 + 8'(j));
      tick();
    end
    chk("mid_level3", 192'(fifo_level), 192'(3));
    chk("mid_ccnt", 192'(conflict_cnt), 192'(4));
    chk("mid_icnt", 192'(invalid_cnt), 192'(3));
    rst = 1'b1;
    drive(4'b0001, 4'b0001, 8'h60);
    tick();
    rst = 1'b0;
    drive(4'b0000, 4'b0000, 8'h00);
    chk_idle_zero("midrst");

    // Invalid counted alongside a valid on the same cycle.
    drive(4'b0001, 4'b0100, 8'h40);
    tick();
    chk("inv_cnt1", 192'(invalid_cnt), 192'(1));
    chk("inv_valid", 192'(out_valid), 192'(1));
    out_ready = 1'b1;
    dec_valid = 4'b0000;
    dec_invalid = 4'b1000;
    repeat (65533) @(posedge clk);
    #1;
    chk("inv_fffe", 192'(invalid_cnt), 192'(16'hFFFE));
    chk("inv_drained", 192'(fifo_level), 192'(0));
    for (int j = 0; j < 3; j++) begin
      drive(4'b0000, 4'b0010, 8'h00);
      tick();
      drive(4'b0000, 4'b0000, 8'h00);
      tick();
    end
    chk("inv_sat", 192'(invalid_cnt), 192'(16'hFFFF));
    chk("inv_other_cnt", 192'(drop_cnt), 192'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
